param_sequence_detector: RTL

- Serial bit-stream pattern detector. Successor to the fixed-pattern sequence detector.
- Generalises pattern length and makes the pattern runtime-loadable.
- Adds an input-valid qualifier, selectable overlapping/non-overlapping matching and a saturating match counter.
- Sits between a serial source (e.g. the sequence generator's seq output) and downstream logic that consumes the one-cycle match pulse y.

---
 rtl/param_sequence_detector.sv | 73 +++++++
 1 files changed

// File: rtl/param_sequence_detector.sv
// Serial pattern detector with a runtime-loadable pattern, valid qualifier,
// selectable overlapping matching and a saturating match counter.
module param_sequence_detector #(
   parameter int                 PAT_LEN     = 4,
   parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
   parameter int                 CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               x,
   input  logic               load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               overlap_en,
   input  logic               clr_count,
   output logic               y,
   output logic [CNT_W-1:0]   match_count
);

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [PAT_LEN-1:0] pat;
   logic [PAT_LEN-1:0] hist;
   logic [PAT_LEN-1:0] window;
   logic [FILL_W-1:0]  fill;
   logic               match;

   // fill counts bits that may still belong to a match; it arms the compare
   // once the incoming bit completes a full window.
   always_comb begin
      window = {hist[PAT_LEN-2:0], x};
      match  = en && !load && (fill >= FILL_ARM) && (window == pat);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat  <= DEFAULT_PAT;
         hist <= '0;
         fill <= '0;
         y    <= 1'b0;
      end else if (load) begin
         pat  <= pat_in;
         hist <= '0;
         fill <= '0;
         y    <= 1'b0;
      end else if (en) begin
         hist <= window;
         y    <= match;
         if (match) begin
            fill <= overlap_en ? FILL_FULL : '0;
         end else if (fill != FILL_FULL) begin
            fill <= fill + 1'b1;
         end
      end else begin
         y <= 1'b0;
      end
   end

   // Clear wins over a coincident match; the count never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_count <= '0;
      end else if (clr_count) begin
         match_count <= '0;
      end else if (match && (match_count != CNT_MAX)) begin
         match_count <= match_count + 1'b1;
      end
   end

endmodule
